// File: rtl/dff_bank_ovr.sv
// dff_bank_ovr: WIDTH-bit register bank with load/shift datapath, per-bit clear/preset
// overrides applied combinationally to q, and a saturating counter of override assertions.
module dff_bank_ovr #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
   parameter int               CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   input  logic [WIDTH-1:0] clr_mask,
   input  logic [WIDTH-1:0] pre_mask,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             ovr_active,
   output logic [CNT_W-1:0] ovr_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] state_r;
   logic [WIDTH-1:0] q_s;
   logic [WIDTH-1:0] mask_s;
   logic [WIDTH-1:0] next_s;
   logic [WIDTH-1:0] upd_s;
   logic             ovr_prev_r;
   logic [CNT_W-1:0] cnt_r;

   // Visible value: clear wins over preset, unmasked bits show the stored state
   always_comb begin
      mask_s = clr_mask | pre_mask;
      q_s    = ~clr_mask & (pre_mask | state_r);
   end

   // Next-state datapath sourced from the post-override value; masked bits capture their forced level
   always_comb begin
      next_s = state_r;
      if (en) begin
         case (mode)
            2'b00:   next_s = d;
            2'b01:   next_s = {q_s[WIDTH-2:0], sin};
            2'b10:   next_s = {sin, q_s[WIDTH-1:1]};
            2'b11:   next_s = q_s;
            default: next_s = q_s;
         endcase
      end else begin
         next_s = state_r;
      end
      upd_s = (mask_s & q_s) | (~mask_s & next_s);
   end

   // State register, override edge detector and saturating event counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= RESET_VAL;
         ovr_prev_r <= 1'b0;
         cnt_r      <= {CNT_W{1'b0}};
      end else begin
         state_r    <= upd_s;
         ovr_prev_r <= ovr_active;
         if (ovr_active && !ovr_prev_r && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   assign q          = q_s;
   assign sout       = (mode == 2'b01) ? q_s[WIDTH-1] : q_s[0];
   assign ovr_active = |mask_s;
   assign ovr_count  = cnt_r;

endmodule

// File: tb/tb_dff_bank_ovr.sv
// tb_dff_bank_ovr: directed and randomized checks of dff_bank_ovr against a per-bit
// behavioural model; a second instance uses CNT_W=2 and a non-zero reset value.
module tb_dff_bank_ovr;

   localparam logic [7:0] RV2 = 8'h5A;

   logic       clk = 1'b0;
   logic       rst, en, sin;
   logic [1:0] mode;
   logic [7:0] d, clr_mask, pre_mask;
   logic [7:0] q, q2;
   logic       sout, sout2, ovr_active, ovr_active2;
   logic [7:0] ovr_count;
   logic [1:0] ovr_count2;

   int checks = 0;
   int passes = 0;

   logic [7:0] m_s, m_s2;
   int         m_cnt, m_cnt2;
   bit         m_prev;

   dff_bank_ovr #(.WIDTH(8), .RESET_VAL(8'h00), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin(sin),
      .clr_mask(clr_mask), .pre_mask(pre_mask),
      .q(q), .sout(sout), .ovr_active(ovr_active), .ovr_count(ovr_count)
   );

   dff_bank_ovr #(.WIDTH(8), .RESET_VAL(RV2), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin(sin),
      .clr_mask(clr_mask), .pre_mask(pre_mask),
      .q(q2), .sout(sout2), .ovr_active(ovr_active2), .ovr_count(ovr_count2)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] vis(input logic [7:0] s, input logic [7:0] c, input logic [7:0] p);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         if (c[i]) r[i] = 1'b0;
         else if (p[i]) r[i] = 1'b1;
         else r[i] = s[i];
      end
      return r;
   endfunction

   function automatic logic [7:0] model_next(input logic [7:0] s, input logic [7:0] rv);
      int         v;
      logic [7:0] cur, n;
      cur = vis(s, clr_mask, pre_mask);
      if (!en) n = s;
      else if (mode == 2'd0) n = d;
      else if (mode == 2'd1) begin
         v = (int'(cur) * 2 + int'(sin)) % 256;
         n = v[7:0];
      end else if (mode == 2'd2) begin
         v = int'(cur) / 2 + int'(sin) * 128;
         n = v[7:0];
      end else n = cur;
      for (int i = 0; i < 8; i++) begin
         if (clr_mask[i]) n[i] = 1'b0;
         else if (pre_mask[i]) n[i] = 1'b1;
      end
      if (rst) n = rv;
      return n;
   endfunction

   // One clock edge: advance the reference model with the inputs present at the edge
   task automatic tick();
      bit act;
      @(posedge clk);
      act  = ((clr_mask | pre_mask) != 8'h00);
      m_s  = model_next(m_s, 8'h00);
      m_s2 = model_next(m_s2, RV2);
      if (rst) begin
         m_cnt = 0; m_cnt2 = 0; m_prev = 1'b0;
      end else begin
         if (act && !m_prev) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
         end
         m_prev = act;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; mode = 2'b00; d = 8'hFF; sin = 1'b1;
      clr_mask = 8'h00; pre_mask = 8'h00;
      tick();
      checks++; if (q !== 8'h00) $display("FAIL reset_q: got %h expected 00", q); else passes++;
      checks++; if (q2 !== RV2) $display("FAIL reset_q2: got %h expected %h", q2, RV2); else passes++;
      checks++; if (ovr_count !== 8'd0) $display("FAIL reset_cnt: got %0d expected 0", ovr_count); else passes++;
      checks++; if (ovr_active !== 1'b0) $display("FAIL reset_active: got %b expected 0", ovr_active); else passes++;
      rst = 1'b0;
   endtask

   task automatic test_load_shift();
      en = 1'b1; mode = 2'b00; d = 8'hA5;
      tick();
      checks++; if (q !== 8'hA5) $display("FAIL load_q: got %h expected a5", q); else passes++;
      mode = 2'b01; sin = 1'b1; #1;
      checks++; if (sout !== 1'b1) $display("FAIL shl_sout: got %b expected 1", sout); else passes++;
      tick();
      checks++; if (q !== 8'h4B) $display("FAIL shl_q: got %h expected 4b", q); else passes++;
      mode = 2'b10; sin = 1'b0; #1;
      checks++; if (sout !== 1'b1) $display("FAIL shr_sout: got %b expected 1", sout); else passes++;
      tick();
      checks++; if (q !== 8'h25) $display("FAIL shr_q: got %h expected 25", q); else passes++;
      mode = 2'b11; d = 8'h00;
      tick();
      checks++; if (q !== 8'h25) $display("FAIL hold_q: got %h expected 25", q); else passes++;
      checks++; if (q2 !== vis(m_s2, clr_mask, pre_mask)) $display("FAIL ls_q2: got %h expected %h", q2, vis(m_s2, clr_mask, pre_mask)); else passes++;
   endtask

   task automatic test_priority();
      en = 1'b1; mode = 2'b00; d = 8'h00;
      tick();
      clr_mask = 8'h01; pre_mask = 8'h03; #1;
      checks++; if (q !== 8'h02) $display("FAIL prio_q: got %h expected 02", q); else passes++;
      checks++; if (ovr_active !== 1'b1) $display("FAIL prio_active: got %b expected 1", ovr_active); else passes++;
      en = 1'b0;
      tick(); tick();
      clr_mask = 8'h00; pre_mask = 8'h00; #1;
      checks++; if (q !== 8'h02) $display("FAIL prio_keep: got %h expected 02", q); else passes++;
   endtask

   task automatic test_release();
      en = 1'b1; mode = 2'b00; d = 8'hFF;
      tick();
      en = 1'b0; clr_mask = 8'hF0; pre_mask = 8'h00;
      tick();
      clr_mask = 8'h00; #1;
      checks++; if (q !== 8'h0F) $display("FAIL rel_keep: got %h expected 0f", q); else passes++;
      en = 1'b1; mode = 2'b00; d = 8'hFF;
      tick();
      checks++; if (q !== 8'hFF) $display("FAIL rel_reload: got %h expected ff", q); else passes++;
   endtask

   task automatic test_counter();
      rst = 1'b1; en = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         pre_mask = 8'h10; tick();
         pre_mask = 8'h00; tick();
         if (i == 2) begin
            checks++; if (ovr_count !== 8'd3) $display("FAIL cnt_three: got %0d expected 3", ovr_count); else passes++;
         end
      end
      checks++; if (ovr_count !== 8'd5) $display("FAIL cnt_five: got %0d expected 5", ovr_count); else passes++;
      checks++; if (ovr_count2 !== 2'd3) $display("FAIL cnt_sat: got %0d expected 3", ovr_count2); else passes++;
   endtask

   task automatic test_reset_mid();
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         clr_mask = 8'h80; tick();
         clr_mask = 8'h00; tick();
      end
      en = 1'b1; mode = 2'b00; d = 8'h3C;
      tick();
      checks++; if (ovr_count !== 8'd2) $display("FAIL mid_cnt2: got %0d expected 2", ovr_count); else passes++;
      en = 1'b0; clr_mask = 8'h01; rst = 1'b1;
      tick();
      checks++; if (q !== 8'h00) $display("FAIL mid_q: got %h expected 00", q); else passes++;
      checks++; if (ovr_count !== 8'd0) $display("FAIL mid_cnt0: got %0d expected 0", ovr_count); else passes++;
      checks++; if (q2 !== 8'h5A) $display("FAIL mid_q2: got %h expected 5a", q2); else passes++;
      rst = 1'b0;
      tick();
      checks++; if (ovr_count !== 8'd1) $display("FAIL mid_cnt1: got %0d expected 1", ovr_count); else passes++;
      checks++; if (ovr_count2 !== 2'd1) $display("FAIL mid_cnt1b: got %0d expected 1", ovr_count2); else passes++;
      clr_mask = 8'h00;
   endtask

   task automatic test_random();
      logic [7:0] eq, eq2;
      logic       es;
      for (int n = 0; n < 300; n++) begin
         rst  = ($urandom_range(0, 31) == 0);
         en   = ($urandom_range(0, 3) != 0);
         mode = 2'($urandom_range(0, 3));
         d    = 8'($urandom);
         sin  = 1'($urandom);
         clr_mask = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom & $urandom & $urandom);
         pre_mask = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom & $urandom);
         #1;
         eq  = vis(m_s, clr_mask, pre_mask);
         eq2 = vis(m_s2, clr_mask, pre_mask);
         es  = (mode == 2'b01) ? eq[7] : eq[0];
         checks++; if (q !== eq) $display("FAIL rnd_q: got %h expected %h", q, eq); else passes++;
         checks++; if (q2 !== eq2) $display("FAIL rnd_q2: got %h expected %h", q2, eq2); else passes++;
         checks++; if (sout !== es) $display("FAIL rnd_sout: got %b expected %b", sout, es); else passes++;
         checks++; if (ovr_active !== ((clr_mask | pre_mask) != 8'h00)) $display("FAIL rnd_active: got %b", ovr_active); else passes++;
         checks++; if (ovr_count !== 8'(m_cnt)) $display("FAIL rnd_cnt: got %0d expected %0d", ovr_count, m_cnt); else passes++;
         checks++; if (ovr_count2 !== 2'(m_cnt2)) $display("FAIL rnd_cnt2: got %0d expected %0d", ovr_count2, m_cnt2); else passes++;
         tick();
      end
   endtask

   initial begin
      m_s = 8'h00; m_s2 = 8'h00; m_cnt = 0; m_cnt2 = 0; m_prev = 1'b0;
      rst = 1'b1; en = 1'b0; mode = 2'b00; d = 8'h00; sin = 1'b0;
      clr_mask = 8'h00; pre_mask = 8'h00;
      #1;
      test_reset();
      test_load_shift();
      test_priority();
      test_release();
      test_counter();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
